pic_cw_config_engine: RTL and testbench

Clocked, parametrised successor to the PIC command-word front end. It decodes ICW1–ICW4 and OCW1–OCW3 writes from the data bus buffer through an explicit initialisation state machine. It holds the resulting configuration, mask and mode registers, and emits one-cycle command pulses to the priority resolver and ISR logic. An optional register read-back path is included. It sits between the bus/read-write logic and the interrupt core of the PIC.

---
 rtl/pic_cw_config_engine.sv | 164 ++++++++++++++++
 tb/tb_pic_cw_config_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pic_cw_config_engine.sv
// pic_cw_config_engine: ICW1-ICW4 / OCW1-OCW3 decode, init FSM, config/mask/mode registers and command pulses.
// Optional register read-back path is built when PIC_CW_READBACK_EN is defined.
module pic_cw_config_engine #(
    parameter int N_IRQ  = 8,
    parameter int N_CASC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data_bus_buffer,
    input  logic              cs_neg,
    input  logic              wr_neg,
    input  logic              rd_neg,
    input  logic              a0,
    input  logic              sp_neg,
    output logic              single_mode_flag,
    output logic              level_trigger_flag,
    output logic [4:0]        vector_base,
    output logic [N_CASC-1:0] slaves_connected_flag,
    output logic [2:0]        my_slave_id,
    output logic              aeoi_flag,
    output logic [N_IRQ-1:0]  imr,
    output logic              ocw2_strobe,
    output logic [2:0]        ocw2_cmd,
    output logic [2:0]        ocw2_level,
    output logic              automatic_rotation_mode_flag,
    output logic              special_mask_mode_flag,
    output logic              read_isr_flag,
    output logic              poll_request,
    output logic              cmd_error,
    output logic              ready_to_accept_interrupts_flag,
    output logic [7:0]        data_out,
    output logic              data_out_en
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic       wr_q, ic4;
    logic       we, icw1, a0_wr, in_ready, ocw2, ocw2_bad, ocw3, ocw3_bad;
    logic [7:0] d;

    assign d        = data_bus_buffer;
    assign we       = ~cs_neg & ~wr_neg & wr_q;
    assign icw1     = we & ~a0 & d[4];
    assign a0_wr    = we & a0;
    assign in_ready = (state == READY);
    assign ocw2     = we & in_ready & ~a0 & (d[4:3] == 2'b00);
    assign ocw2_bad = d[6] & ({1'b0, d[2:0]} >= 4'(N_IRQ));
    assign ocw3     = we & in_ready & ~a0 & (d[4:3] == 2'b01) & ~d[7];
    assign ocw3_bad = we & in_ready & ~a0 & (d[4:3] == 2'b01) & d[7];
    assign ready_to_accept_interrupts_flag = in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Initialisation sequencing: ICW1 restarts from anywhere, A0=1 writes advance the WAIT states
    always_comb begin
        state_nx = state;
        if (icw1) begin
            state_nx = WAIT_ICW2;
        end else if (a0_wr) begin
            case (state)
                WAIT_ICW2: state_nx = !single_mode_flag ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
                WAIT_ICW3: state_nx = ic4 ? WAIT_ICW4 : READY;
                WAIT_ICW4: state_nx = READY;
                default:   state_nx = state;
            endcase
        end
    end

    // Configuration, mask and mode registers plus one-cycle command pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q                         <= 1'b1;
            ic4                          <= 1'b0;
            single_mode_flag             <= 1'b0;
            level_trigger_flag           <= 1'b0;
            vector_base                  <= '0;
            slaves_connected_flag        <= '0;
            my_slave_id                  <= '0;
            aeoi_flag                    <= 1'b0;
            imr                          <= '0;
            ocw2_strobe                  <= 1'b0;
            ocw2_cmd                     <= '0;
            ocw2_level                   <= '0;
            automatic_rotation_mode_flag <= 1'b0;
            special_mask_mode_flag       <= 1'b0;
            read_isr_flag                <= 1'b0;
            poll_request                 <= 1'b0;
            cmd_error                    <= 1'b0;
        end else begin
            wr_q         <= wr_neg;
            ocw2_strobe  <= 1'b0;
            poll_request <= 1'b0;
            cmd_error    <= 1'b0;
            if (icw1) begin
                single_mode_flag             <= d[1];
                level_trigger_flag           <= d[3];
                ic4                          <= d[0];
                imr                          <= '0;
                aeoi_flag                    <= 1'b0;
                automatic_rotation_mode_flag <= 1'b0;
                special_mask_mode_flag       <= 1'b0;
                read_isr_flag                <= 1'b0;
            end else if (a0_wr) begin
                case (state)
                    WAIT_ICW2: vector_base <= d[7:3];
                    WAIT_ICW3: begin
                        if (sp_neg) slaves_connected_flag <= d[N_CASC-1:0];
                        else        my_slave_id           <= d[2:0];
                    end
                    WAIT_ICW4: aeoi_flag <= d[1];
                    READY:     imr       <= d[N_IRQ-1:0];
                    default:   ;
                endcase
            end else if (ocw2) begin
                if (ocw2_bad) begin
                    cmd_error <= 1'b1;
                end else begin
                    ocw2_cmd    <= d[7:5];
                    ocw2_level  <= d[2:0];
                    ocw2_strobe <= 1'b1;
                    if (d[7:5] == 3'b100)      automatic_rotation_mode_flag <= 1'b1;
                    else if (d[7:5] == 3'b000) automatic_rotation_mode_flag <= 1'b0;
                end
            end else if (ocw3) begin
                if (d[1]) read_isr_flag          <= d[0];
                if (d[6]) special_mask_mode_flag <= d[5];
                poll_request <= d[2];
            end else if (ocw3_bad) begin
                cmd_error <= 1'b1;
            end
        end
    end

`ifdef PIC_CW_READBACK_EN
    // Registered read-back: IMR on A0=1, status byte on A0=0; a concurrent write wins
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= '0;
            data_out_en <= 1'b0;
        end else if (~cs_neg & ~rd_neg & ~we) begin
            data_out    <= a0 ? 8'(imr) : {in_ready, state, aeoi_flag, single_mode_flag,
                                           level_trigger_flag, special_mask_mode_flag};
            data_out_en <= 1'b1;
        end else begin
            data_out_en <= 1'b0;
        end
    end
`else
    logic rd_unused;
    assign rd_unused   = rd_neg;
    assign data_out    = '0;
    assign data_out_en = 1'b0;
`endif
endmodule

// File: tb/tb_pic_cw_config_engine.sv
// tb_pic_cw_config_engine: directed checks on an N_IRQ=8/N_CASC=8 and an N_IRQ=4/N_CASC=4 instance.
module tb_pic_cw_config_engine;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] d = 8'h00;
    logic       cs_neg = 1'b1, wr_neg = 1'b1, rd_neg = 1'b1, a0 = 1'b0, sp_neg = 1'b1;
    int         checks = 0, errors = 0, cnt;

    logic       s8, l8, ae8, st8, rot8, smm8, ris8, poll8, err8, rdy8, den8;
    logic [4:0] vb8;
    logic [7:0] scf8, imr8, do8;
    logic [2:0] id8, cmd8, lvl8;
    logic       s4, l4, ae4, st4, rot4, smm4, ris4, poll4, err4, rdy4, den4;
    logic [4:0] vb4;
    logic [3:0] scf4, imr4;
    logic [7:0] do4;
    logic [2:0] id4, cmd4, lvl4;

    always #5 clk = ~clk;

    pic_cw_config_engine u_dut8 (
        .clk(clk), .rst(rst), .data_bus_buffer(d), .cs_neg(cs_neg), .wr_neg(wr_neg),
        .rd_neg(rd_neg), .a0(a0), .sp_neg(sp_neg),
        .single_mode_flag(s8), .level_trigger_flag(l8), .vector_base(vb8),
        .slaves_connected_flag(scf8), .my_slave_id(id8), .aeoi_flag(ae8), .imr(imr8),
        .ocw2_strobe(st8), .ocw2_cmd(cmd8), .ocw2_level(lvl8),
        .automatic_rotation_mode_flag(rot8), .special_mask_mode_flag(smm8),
        .read_isr_flag(ris8), .poll_request(poll8), .cmd_error(err8),
        .ready_to_accept_interrupts_flag(rdy8), .data_out(do8), .data_out_en(den8)
    );

    pic_cw_config_engine #(.N_IRQ(4), .N_CASC(4)) u_dut4 (
        .clk(clk), .rst(rst), .data_bus_buffer(d), .cs_neg(cs_neg), .wr_neg(wr_neg),
        .rd_neg(rd_neg), .a0(a0), .sp_neg(sp_neg),
        .single_mode_flag(s4), .level_trigger_flag(l4), .vector_base(vb4),
        .slaves_connected_flag(scf4), .my_slave_id(id4), .aeoi_flag(ae4), .imr(imr4),
        .ocw2_strobe(st4), .ocw2_cmd(cmd4), .ocw2_level(lvl4),
        .automatic_rotation_mode_flag(rot4), .special_mask_mode_flag(smm4),
        .read_isr_flag(ris4), .poll_request(poll4), .cmd_error(err4),
        .ready_to_accept_interrupts_flag(rdy4), .data_out(do4), .data_out_en(den4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic addr, input logic [7:0] v);
        @(negedge clk);
        cs_neg = 1'b0; a0 = addr; d = v; wr_neg = 1'b0;
        @(negedge clk);
        wr_neg = 1'b1; cs_neg = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", rdy8, 0);
        check("rst_imr", imr8, 0);
        check("rst_vb", vb8, 0);
        check("rst_aeoi", ae8, 0);
        check("rst_pulses", {st8, poll8, err8}, 0);
        check("rst_dout", {den8, do8}, 0);
        rst = 1'b0;

        wr(0, 8'h13);
        check("icw1_notready", rdy8, 0);
        wr(1, 8'h48);
        check("icw2_vb", vb8, 5'h09);
        check("icw2_single", s8, 1);
        check("icw2_wait4", rdy8, 0);
        wr(1, 8'h03);
        check("icw4_aeoi", ae8, 1);
        check("icw4_ready", rdy8, 1);

        wr(1, 8'hA5);
        check("ocw1_imr8", imr8, 8'hA5);
        check("ocw1_imr4", imr4, 4'h5);

        wr(0, 8'h13);
        check("reicw1_imr", imr8, 0);
        check("reicw1_ready", rdy8, 0);
        check("reicw1_aeoi", ae8, 0);
        wr(0, 8'h08);
        check("ign_wait_vb", vb8, 5'h09);
        check("ign_wait_rdy", rdy8, 0);
        wr(1, 8'h50);
        check("icw2b_vb", vb8, 5'h0A);
        wr(1, 8'h01);
        check("icw4b_aeoi", ae8, 0);
        check("icw4b_ready", rdy8, 1);

        wr(0, 8'h66);
        check("ocw2_bad_err4", err4, 1);
        check("ocw2_bad_st4", st4, 0);
        check("ocw2_ok_st8", st8, 1);
        check("ocw2_ok_cmd8", cmd8, 3'b011);
        check("ocw2_ok_lvl8", lvl8, 6);
        check("ocw2_bad_cmd4", cmd4, 0);
        @(negedge clk);
        check("ocw2_err_1cyc", {err4, st8}, 0);
        wr(0, 8'h62);
        check("ocw2_st4", st4, 1);
        check("ocw2_cmd4", cmd4, 3'b011);
        check("ocw2_lvl4", lvl4, 2);
        check("ocw2_noerr4", err4, 0);
        @(negedge clk);
        check("ocw2_st_1cyc", st4, 0);
        wr(0, 8'h80);
        check("rot_set", rot4, 1);
        wr(0, 8'h20);
        check("rot_keep", rot4, 1);
        check("rot_keep_cmd", cmd4, 3'b001);
        wr(0, 8'h00);
        check("rot_clr", rot4, 0);

        wr(0, 8'h6F);
        check("ocw3_smm", smm4, 1);
        check("ocw3_ris", ris4, 1);
        check("ocw3_poll", poll4, 1);
        @(negedge clk);
        check("ocw3_poll_1cyc", poll4, 0);

        @(negedge clk);
        cs_neg = 1'b0; a0 = 1'b0; d = 8'h0C; wr_neg = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            cnt += int'(poll4);
        end
        wr_neg = 1'b1; cs_neg = 1'b1;
        check("hold_low_polls", cnt, 1);
        check("hold_smm_keep", {smm4, ris4}, 2'b11);
        wr(0, 8'h4A);
        check("ocw3_clr", {smm4, ris4, poll4}, 0);
        wr(0, 8'h88);
        check("ocw3_d7_err", {err8, err4}, 2'b11);

        sp_neg = 1'b1;
        wr(0, 8'h11);
        wr(1, 8'h20);
        check("casc_vb", vb8, 5'h04);
        check("casc_wait3", rdy8, 0);
        wr(1, 8'hF5);
        check("casc_scf4", scf4, 4'h5);
        check("casc_scf8", scf8, 8'hF5);
        check("casc_wait4", rdy4, 0);
        wr(1, 8'h01);
        check("casc_aeoi", ae4, 0);
        check("casc_ready", rdy4, 1);
        check("casc_single", s4, 0);

        sp_neg = 1'b0;
        wr(0, 8'h11);
        wr(1, 8'h28);
        wr(1, 8'h03);
        check("slave_id", id8, 3);
        check("slave_scf_keep", scf8, 8'hF5);
        wr(1, 8'h02);
        check("slave_aeoi", ae8, 1);
        check("slave_ready", rdy8, 1);

        wr(0, 8'h12);
        wr(1, 8'h40);
        check("noicw4_ready", rdy8, 1);
        check("noicw4_aeoi", ae8, 0);
        check("noicw4_vb", vb8, 5'h08);

        sp_neg = 1'b1;
        wr(0, 8'h19);
        check("ltim", l8, 1);
        wr(1, 8'h30);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_vb", vb8, 0);
        check("midrst_ltim", l8, 0);
        check("midrst_ready", rdy8, 0);
        check("midrst_id", id8, 0);
        wr(1, 8'hFF);
        check("idle_ign_scf", scf8, 0);
        check("idle_ign_vb", vb8, 0);
        check("idle_ign_imr", imr8, 0);
        check("idle_ign_rdy", rdy8, 0);

        @(negedge clk);
        cs_neg = 1'b0; rd_neg = 1'b0; a0 = 1'b1;
        @(negedge clk);
`ifdef PIC_CW_READBACK_EN
        check("rd_imr", {den8, do8}, 9'h100);
`else
        check("rd_disabled", {den8, do8}, 0);
`endif
        cs_neg = 1'b1; rd_neg = 1'b1;
        @(negedge clk);
        check("rd_en_drop", den8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
